// File: rtl/modn_pkg.sv
// Shared constants and types for the mod-N counter and its config loader.
package modn_pkg;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_MIN_MOD = 2;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  function automatic logic is_legal_mod(
    input int unsigned v,
    input int unsigned min_mod
  );
    return v >= min_mod;
  endfunction

endpackage

// File: rtl/modn_cfg_loader.sv
// Modulus config loader: accepts updates, applies them on the counter wrap.
// Optional forced apply after TIMEOUT_CYC pending cycles: MODN_APPLY_TIMEOUT_EN.
module modn_cfg_loader
  import modn_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_MOD = 10,
  parameter int MIN_MOD     = DEF_MIN_MOD,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_modn,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] modN,
  output logic             cfg_err,
  output logic             cfg_applied,
  output logic             pending,
  output logic             cfg_timeout
);

  localparam logic [WIDTH-1:0] RST_MOD = WIDTH'(DEFAULT_MOD);

  if (DEFAULT_MOD < MIN_MOD || DEFAULT_MOD > (2**WIDTH) - 1)
    $error("DEFAULT_MOD out of legal range");
  if (TIMEOUT_CYC < 1)
    $error("TIMEOUT_CYC must be positive");

  state_t           r_state;
  logic [WIDTH-1:0] r_modn;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ready;
  logic             r_pending;
  logic             r_err;
  logic             r_applied;
  logic             r_timeout;
  logic             w_wrap;
  logic             w_legal;

`ifdef MODN_APPLY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_tcnt;
`endif

  // Out-of-range counts are treated as a wrap so a stuck counter recovers.
  assign w_wrap  = (count_in == r_modn - WIDTH'(1)) ||
                   (count_in >= r_modn);
  assign w_legal = is_legal_mod(32'(cfg_modn),
                                unsigned'(MIN_MOD));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_modn    <= RST_MOD;
      r_shadow  <= RST_MOD;
      r_ready   <= 1'b1;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_applied <= 1'b0;
      r_timeout <= 1'b0;
`ifdef MODN_APPLY_TIMEOUT_EN
      r_tcnt    <= '0;
`endif
    end else begin
      r_err     <= 1'b0;
      r_applied <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cfg_valid) begin
            if (w_legal) begin
              r_shadow  <= cfg_modn;
              r_state   <= PENDING;
              r_ready   <= 1'b0;
              r_pending <= 1'b1;
`ifdef MODN_APPLY_TIMEOUT_EN
              r_tcnt    <= '0;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (w_wrap) begin
            r_modn    <= r_shadow;
            r_applied <= 1'b1;
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_pending <= 1'b0;
`ifdef MODN_APPLY_TIMEOUT_EN
          end else if (r_tcnt == T_LAST) begin
            r_modn    <= r_shadow;
            r_applied <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_pending <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign modN        = r_modn;
  assign cfg_ready   = r_ready;
  assign pending     = r_pending;
  assign cfg_err     = r_err;
  assign cfg_applied = r_applied;
  assign cfg_timeout = r_timeout;

endmodule

// File: tb/tb_modn_cfg_loader.sv
// Directed bench for modn_cfg_loader; covers the timeout path
// when built with MODN_APPLY_TIMEOUT_EN.
module tb_modn_cfg_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_modn;
  logic [5:0] count_in;
  logic [5:0] modN;
  logic       cfg_err;
  logic       cfg_applied;
  logic       pending;
  logic       cfg_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modn_cfg_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_modn   (cfg_modn),
    .count_in   (count_in),
    .modN       (modN),
    .cfg_err    (cfg_err),
    .cfg_applied(cfg_applied),
    .pending    (pending),
    .cfg_timeout(cfg_timeout)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input int m, input int rdy,
                    input int pnd, input int err, input int app,
                    input int tmo);
    chk({tag, ".modN"},    int'(modN),        m);
    chk({tag, ".ready"},   int'(cfg_ready),   rdy);
    chk({tag, ".pending"}, int'(pending),     pnd);
    chk({tag, ".err"},     int'(cfg_err),     err);
    chk({tag, ".applied"}, int'(cfg_applied), app);
    chk({tag, ".timeout"}, int'(cfg_timeout), tmo);
  endtask

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_modn  = 6'd0;
    count_in  = 6'd0;
    repeat (3) @(negedge clk);
    st("reset_held", 10, 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk);
    st("reset", 10, 1, 0, 0, 0, 0);

    // legal update 5 offered at count 3
    count_in = 6'd3; cfg_valid = 1'b1; cfg_modn = 6'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    st("accept5", 10, 0, 1, 0, 0, 0);
    for (int c = 4; c <= 8; c++) begin
      count_in = 6'(c);
      @(negedge clk);
      st("wait5", 10, 0, 1, 0, 0, 0);
    end
    count_in = 6'd9;
    @(negedge clk);
    st("apply5", 5, 1, 0, 0, 1, 0);
    count_in = 6'd0;
    @(negedge clk);
    st("post5", 5, 1, 0, 0, 0, 0);

    // illegal values 1 then 0
    cfg_valid = 1'b1; cfg_modn = 6'd1;
    @(negedge clk);
    st("ill1", 5, 1, 0, 1, 0, 0);
    cfg_modn = 6'd0;
    @(negedge clk);
    st("ill0", 5, 1, 0, 1, 0, 0);
    cfg_valid = 1'b0;
    @(negedge clk);
    st("ill_end", 5, 1, 0, 0, 0, 0);

    // back-pressure: 6 accepted, 7 held until ready
    cfg_valid = 1'b1; cfg_modn = 6'd6; count_in = 6'd0;
    @(negedge clk);
    st("acc6", 5, 0, 1, 0, 0, 0);
    cfg_modn = 6'd7;
    count_in = 6'd1;
    @(negedge clk);
    st("bp1", 5, 0, 1, 0, 0, 0);
    count_in = 6'd2;
    @(negedge clk);
    st("bp2", 5, 0, 1, 0, 0, 0);
    count_in = 6'd4;
    @(negedge clk);
    st("apply6", 6, 1, 0, 0, 1, 0);
    count_in = 6'd0;
    @(negedge clk);
    st("acc7", 6, 0, 1, 0, 0, 0);
    cfg_valid = 1'b0;
    count_in = 6'd5;
    @(negedge clk);
    st("apply7", 7, 1, 0, 0, 1, 0);

    // out-of-range count counts as wrap
    cfg_valid = 1'b1; cfg_modn = 6'd9; count_in = 6'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    count_in = 6'd40;
    @(negedge clk);
    st("oor_wrap", 9, 1, 0, 0, 1, 0);

    // async reset mid-pending discards shadow
    cfg_valid = 1'b1; cfg_modn = 6'd3; count_in = 6'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    st("acc3", 9, 0, 1, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    st("async_rst", 10, 1, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    count_in = 6'd9;
    @(negedge clk);
    st("no_stale", 10, 1, 0, 0, 0, 0);

    // timeout path with counter stuck at 0
    cfg_valid = 1'b1; cfg_modn = 6'd12; count_in = 6'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    st("acc12", 10, 0, 1, 0, 0, 0);
`ifdef MODN_APPLY_TIMEOUT_EN
    repeat (63) @(negedge clk);
    st("pre_tmo", 10, 0, 1, 0, 0, 0);
    @(negedge clk);
    st("tmo", 12, 1, 0, 0, 1, 1);
    @(negedge clk);
    st("post_tmo", 12, 1, 0, 0, 0, 0);
`else
    repeat (100) @(negedge clk);
    st("no_tmo", 10, 0, 1, 0, 0, 0);
    count_in = 6'd9;
    @(negedge clk);
    st("apply12", 12, 1, 0, 0, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
